// File: rtl/uart_hex_seg_display.sv
// ---------------------------------------------------------------------------
// uart_hex_seg_display
//
// Shows the most recent hex characters received from a UART receiver in a
// left-shifting window on a multiplexed 7-segment display, with a BCD count
// of accepted characters in the rightmost CNT_DIGITS digits.
//
// Byte handling (taken on the rising edge of rx_valid only):
//   hex char  ('0'-'9','A'-'F','a'-'f') : shift window left, insert, count+1
//   0x08 backspace                      : drop newest char, shift right
//   0x1B escape                         : clear window, count = 0
//   anything else                       : ignored
//
// Parameters:
//   NUM_DIGITS     total multiplexed digits (2..8)
//   CNT_DIGITS     digits used by the decimal counter (0..NUM_DIGITS-1)
//   SCAN_DIV       clk cycles each digit stays enabled (>=2)
//   SEG_ACTIVE_LOW 1: segment/enable lines active-low, 0: active-high
//
// Optional build macro:
//   SEG_COUNT_ZERO_BLANK_EN  blank leading zeros of the count field
//                            (rightmost count digit always shown)
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   rx_data   received ASCII byte, valid while rx_valid is high
//   rx_valid  level flag from the UART receiver
//   seg_en    digit enables, bit 0 = rightmost digit, one-hot in active level
//   seg_out   registered segments {dp,g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module uart_hex_seg_display #(
    parameter int NUM_DIGITS     = 8,
    parameter int CNT_DIGITS     = 2,
    parameter int SCAN_DIV       = 100000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [NUM_DIGITS-1:0] seg_en,
    output logic [7:0]            seg_out
);

    localparam int SLOTS = NUM_DIGITS - CNT_DIGITS;
    localparam int CNT_N = (CNT_DIGITS > 0) ? CNT_DIGITS : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int SCW   = $clog2(SCAN_DIV);

    // Glyphs are built active-low internally and inverted at the output
    // register when the board wants active-high lines.
    localparam logic [7:0] BLANK_AL = 8'hFF;
    localparam logic [NUM_DIGITS-1:0] EN_ONE = NUM_DIGITS'(1);

    function automatic logic [7:0] glyph_al(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
            4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
            4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
            4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
        endcase
        return g;
    endfunction

    // ---------------------------------------------------------------- input
    logic       rx_prev;
    logic       rx_event;
    logic       is_hex;
    logic       is_bs;
    logic       is_esc;
    logic [3:0] hex_nib;

    assign rx_event = rx_valid & ~rx_prev;

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, otherwise a latch is inferred.
    always_comb begin
        is_hex  = 1'b0;
        hex_nib = 4'h0;
        is_bs   = (rx_data == 8'h08);
        is_esc  = (rx_data == 8'h1B);
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            is_hex  = 1'b1;
            hex_nib = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            is_hex  = 1'b1;
            hex_nib = rx_data[3:0] + 4'd9;   // 'A'/'a' low nibble 1 -> 10
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_prev <= 1'b0;
        else     rx_prev <= rx_valid;
    end

    // ---------------------------------------------------------- char window
    // Slot 0 is the newest character (digit CNT_DIGITS); higher slots are
    // older and sit further left. Valid slots are always contiguous from 0.
    logic       slot_valid [SLOTS];
    logic [3:0] slot_nib   [SLOTS];

    // NOTE: the slot array is a handful of flops, not a RAM, so it is reset;
    // empty slots must read as blank straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                slot_valid[i] <= 1'b0;
                slot_nib[i]   <= 4'h0;
            end
        end else if (rx_event) begin
            if (is_hex) begin
                for (int i = SLOTS - 1; i >= 1; i--) begin
                    slot_valid[i] <= slot_valid[i-1];
                    slot_nib[i]   <= slot_nib[i-1];
                end
                slot_valid[0] <= 1'b1;
                slot_nib[0]   <= hex_nib;
            end else if (is_bs && slot_valid[0]) begin
                for (int i = 0; i < SLOTS - 1; i++) begin
                    slot_valid[i] <= slot_valid[i+1];
                    slot_nib[i]   <= slot_nib[i+1];
                end
                slot_valid[SLOTS-1] <= 1'b0;
                slot_nib[SLOTS-1]   <= 4'h0;
            end else if (is_esc) begin
                for (int i = 0; i < SLOTS; i++) begin
                    slot_valid[i] <= 1'b0;
                    slot_nib[i]   <= 4'h0;
                end
            end
        end
    end

    // ---------------------------------------------------------- BCD counter
    logic [3:0] cnt [CNT_N];

    generate
        if (CNT_DIGITS > 0) begin : g_cnt
            // carry[i] = every lower digit is 9, so digit i steps this time.
            logic [CNT_N:0] carry;

            always_comb begin
                carry[0] = 1'b1;
                for (int i = 0; i < CNT_N; i++)
                    carry[i+1] = carry[i] & (cnt[i] == 4'd9);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < CNT_N; i++) cnt[i] <= 4'd0;
                end else if (rx_event) begin
                    if (is_hex) begin
                        for (int i = 0; i < CNT_N; i++)
                            if (carry[i])
                                cnt[i] <= (cnt[i] == 4'd9) ? 4'd0 : cnt[i] + 4'd1;
                    end else if (is_esc) begin
                        for (int i = 0; i < CNT_N; i++) cnt[i] <= 4'd0;
                    end
                end
            end
        end else begin : g_no_cnt
            always_comb begin
                for (int i = 0; i < CNT_N; i++) cnt[i] = 4'd0;
            end
        end
    endgenerate

    // ----------------------------------------------------------------- scan
    logic [SCW-1:0]   scan_cnt;
    logic [IDX_W-1:0] scan_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Glyph for the digit currently selected by scan_idx.
    logic [7:0] cur_glyph;

    always_comb begin
        int idx;
        int s;
`ifdef SEG_COUNT_ZERO_BLANK_EN
        logic hi_nonzero;
        hi_nonzero = 1'b0;
`endif
        idx       = int'(scan_idx);
        s         = 0;
        cur_glyph = BLANK_AL;
        if (idx < CNT_DIGITS) begin
            cur_glyph = glyph_al(cnt[idx]);
`ifdef SEG_COUNT_ZERO_BLANK_EN
            // A count digit is a leading zero if it and all digits above it
            // are zero; the ones digit is never blanked.
            for (int j = 0; j < CNT_N; j++)
                if (j >= idx && cnt[j] != 4'd0) hi_nonzero = 1'b1;
            if (idx > 0 && !hi_nonzero) cur_glyph = BLANK_AL;
`endif
        end else begin
            s = idx - CNT_DIGITS;
            if (s < SLOTS && slot_valid[s]) cur_glyph = glyph_al(slot_nib[s]);
        end
    end

    // Enable and segments are registered together from the same index so
    // they always change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_en  <= (SEG_ACTIVE_LOW != 0) ? '1 : '0;
            seg_out <= (SEG_ACTIVE_LOW != 0) ? BLANK_AL : ~BLANK_AL;
        end else begin
            seg_en  <= (SEG_ACTIVE_LOW != 0) ? ~(EN_ONE << scan_idx) : (EN_ONE << scan_idx);
            seg_out <= (SEG_ACTIVE_LOW != 0) ? cur_glyph : ~cur_glyph;
        end
    end

endmodule

// File: doc/uart_hex_seg_display.md
Name: uart_hex_seg_display

Overview:
- Parametrised successor to the team's UART-to-7-segment display block.
- Takes received ASCII bytes from the UART receiver and shows the most recent hex characters in a left-shifting window on a multiplexed common-anode display.
- Shows a BCD count of accepted characters in the rightmost digits.
- Adds backspace and clear commands, configurable digit/field widths, configurable scan rate and configurable output polarity.

Parameters:
- NUM_DIGITS, 8, total multiplexed digits (2..8).
- CNT_DIGITS, 2, digits reserved for the decimal counter (0..NUM_DIGITS-1); the char field is NUM_DIGITS-CNT_DIGITS slots.
- SCAN_DIV, 100000, clk cycles each digit stays enabled (>=2).
- SEG_ACTIVE_LOW, 1, 1: segment/enable lines active-low; 0: active-high (both buses inverted).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- rx_data  input  8  received ASCII byte, valid while rx_valid high
- rx_valid  input  1  level flag from UART receiver; a byte is taken on its rising edge only
- seg_en  output  NUM_DIGITS  digit enables, bit 0 = rightmost digit, one-hot in active polarity
- seg_out  output  8  segments {dp,g,f,e,d,c,b,a}, registered

Behaviour:
- Clock and reset: single clock clk; rst asynchronous active-high; all state is cleared on rst assertion regardless of scan position or pending input.
- Reset values:
  - seg_out = blank (all segments off, in active polarity; 8'hFF when SEG_ACTIVE_LOW=1).
  - seg_en = all digits disabled.
  - Char slots empty, count 0, scan index 0, scan counter 0, edge register 0.
- Acceptance:
  - Event = rx_valid high this cycle and low the previous cycle.
  - rx_valid held high for N cycles = exactly one event.
  - rx_data sampled in the event cycle.
- Classification of an event byte:
  - Hex char (0x30-0x39, 0x41-0x46, 0x61-0x66): shift the window one slot left, dropping the oldest. Place the byte in the newest slot (digit CNT_DIGITS). Increment the count.
  - 0x08 backspace: remove the newest char, shift the remaining chars right one slot, mark the leftmost slot empty. On an empty window: no effect. Count unchanged.
  - 0x1B escape: mark all slots empty, count = 0.
  - Any other byte: ignored, no state change.
- Slot storage: each slot holds a valid flag plus a 4-bit nibble. Empty slots display blank. A received '0' displays as 0, never blank.
- Count:
  - CNT_DIGITS cascaded BCD nibbles; no divide or modulo operators.
  - Wraps from all-9s to all-0s (99 -> 00 for CNT_DIGITS=2).
  - Count field is always shown, zero-padded.
  - CNT_DIGITS=0: no counter logic; all digits are char slots.
- Glyphs:
  - 0-9, A, b, C, d, E, F use standard codes (active-low: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E).
  - Lowercase a-f map to the same glyphs as uppercase.
  - dp is always off.
- Scan:
  - Counter counts 0..SCAN_DIV-1, then wraps.
  - On wrap, scan index advances; index NUM_DIGITS-1 wraps to 0.
  - seg_en and seg_out are registered from the current index in the same cycle, so both change together, exactly 1 cycle after the index changes.
- Latency: a state update from an event is visible on seg_out one cycle later when that digit is being scanned, at most SCAN_DIV*NUM_DIGITS+2 cycles after the event.

Optional Feature:
- Macro: SEG_COUNT_ZERO_BLANK_EN.
- Defined: leading zeros of the count field are blanked; the rightmost count digit always shows (count 7 shows " 7", count 0 shows " 0").
- Undefined: count is zero-padded ("07", "00").

Test Plan (NUM_DIGITS=8, CNT_DIGITS=2, SCAN_DIV=4, SEG_ACTIVE_LOW=1):
- Reset then idle -> seg_out=FF, seg_en=FF during reset. After release, digits 7..2 show FF, digit1=C0, digit0=C0.
- Send '1','a','F' with rx_valid pulses -> digits 4,3,2 = F9,88,8E; digits 7..5 = FF; count digits = C0,B0 ("03").
- Hold rx_valid high 20 cycles with 'A' -> exactly one acceptance; count increments by 1.
- Send 8 hex chars '0'..'7' -> window shows 2..7 (digits 7..2 = A4,B0,99,92,82,F8); count "08". Then send 92 more chars -> count wraps to "00".
- After "123", send 0x08 -> digits 3,2 = F9,A4, digit 4 blank, count "03". Send 0x08 three more times -> all slots blank, no underflow. Send 0x1B -> count "00".
- Send 'G' and 0x20 -> no change. Assert rst mid-scan with digit 5 enabled -> seg_en=FF, seg_out=FF immediately (asynchronous), state cleared.
